// File: rtl/regfile_scb_pkg.sv
// rtl/regfile_scb_pkg.sv - shared types and constants for the scoreboarded register file
package regfile_scb_pkg;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_NREGS = 32;

    // Hard-wired zero register.
    localparam int ZERO_ADDR = 0;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_SWEEP = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_e;

endpackage

// File: rtl/regfile_clr_fsm.sv
// rtl/regfile_clr_fsm.sv - clear sequencer that sweeps registers 1..NREGS-1 to zero
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_req    : start request, honoured only when idle
//   idle       : sequencer idle, normal writes/reserves/bypass allowed
//   sweep_en   : sweep_idx entry is being cleared this cycle
//   sweep_idx  : register currently being cleared
//   clr_busy   : sweep in progress (state decode)
//   clr_done   : one-cycle completion pulse (state decode)
import regfile_scb_pkg::*;

module regfile_clr_fsm #(
    parameter int NREGS  = DEF_NREGS,
    parameter int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr_req,
    output logic              idle,
    output logic              sweep_en,
    output logic [ADDR_W-1:0] sweep_idx,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NREGS - 1);
    localparam logic [ADDR_W-1:0] FIRST_IDX = ADDR_W'(1);

    clr_state_e        state, state_nx;
    logic [ADDR_W-1:0] idx, idx_nx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= CLR_IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        idle     = 1'b0;
        sweep_en = 1'b0;
        clr_busy = 1'b0;
        clr_done = 1'b0;
        case (state)
            CLR_IDLE: begin
                idle = 1'b1;
                if (clr_req) begin
                    state_nx = CLR_SWEEP;
                    idx_nx   = FIRST_IDX;
                end
            end
            CLR_SWEEP: begin
                sweep_en = 1'b1;
                clr_busy = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nx = CLR_DONE;
                end else begin
                    idx_nx = idx + FIRST_IDX;
                end
            end
            CLR_DONE: begin
                clr_done = 1'b1;
                state_nx = CLR_IDLE;
            end
            default: begin
                state_nx = CLR_IDLE;
            end
        endcase
    end

    assign sweep_idx = idx;

endmodule

// File: rtl/regfile_scb.sv
// rtl/regfile_scb.sv - 2R1W integer register file with pending scoreboard, bypass and clear sweep
//   clk, rst_n               : clock, asynchronous active-low reset
//   wr_en_i/RD_ADDR_i/data_i : writeback port (clears pending)
//   RS1/RS2_ADDR_i           : combinational read addresses
//   RS1/RS2_data_o, _pend_o  : read data and pending bit
//   rsv_en_i/rsv_addr_i      : issue-time reservation (sets pending)
//   clr_req_i                : start clear sweep
//   clr_busy_o, clr_done_o   : sweep status
import regfile_scb_pkg::*;

module regfile_scb #(
    parameter int  XLEN   = DEF_XLEN,
    parameter int  NREGS  = DEF_NREGS,
    parameter int  BYPASS = 1,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] RD_ADDR_i,
    input  logic [XLEN-1:0]   data_i,
    input  logic [ADDR_W-1:0] RS1_ADDR_i,
    input  logic [ADDR_W-1:0] RS2_ADDR_i,
    output logic [XLEN-1:0]   RS1_data_o,
    output logic [XLEN-1:0]   RS2_data_o,
    output logic              RS1_pend_o,
    output logic              RS2_pend_o,
    input  logic              rsv_en_i,
    input  logic [ADDR_W-1:0] rsv_addr_i,
    input  logic              clr_req_i,
    output logic              clr_busy_o,
    output logic              clr_done_o
);

    localparam logic [ADDR_W-1:0] ZERO = ADDR_W'(ZERO_ADDR);
    localparam logic              BYPASS_ON = (BYPASS != 0);

    logic [XLEN-1:0]   regs [NREGS];
    logic [NREGS-1:0]  pending;

    logic              fsm_idle;
    logic              sweep_en;
    logic [ADDR_W-1:0] sweep_idx;

    regfile_clr_fsm #(
        .NREGS  (NREGS),
        .ADDR_W (ADDR_W)
    ) u_clr_fsm (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_req   (clr_req_i),
        .idle      (fsm_idle),
        .sweep_en  (sweep_en),
        .sweep_idx (sweep_idx),
        .clr_busy  (clr_busy_o),
        .clr_done  (clr_done_o)
    );

    // Writes and reserves only act while idle; the sweep owns the array otherwise.
    logic do_wr, do_rsv;
    assign do_wr  = fsm_idle && wr_en_i  && (RD_ADDR_i  != ZERO);
    assign do_rsv = fsm_idle && rsv_en_i && (rsv_addr_i != ZERO);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (sweep_en) begin
            regs[sweep_idx] <= '0;
        end else if (do_wr) begin
            regs[RD_ADDR_i] <= data_i;
        end
    end

    // Reserve is applied after writeback so a same-cycle new producer keeps the entry pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
        end else if (sweep_en) begin
            pending[sweep_idx] <= 1'b0;
        end else begin
            if (do_wr) begin
                pending[RD_ADDR_i] <= 1'b0;
            end
            if (do_rsv) begin
                pending[rsv_addr_i] <= 1'b1;
            end
        end
    end

    logic byp1, byp2;
    assign byp1 = BYPASS_ON && do_wr && (RD_ADDR_i == RS1_ADDR_i);
    assign byp2 = BYPASS_ON && do_wr && (RD_ADDR_i == RS2_ADDR_i);

    always_comb begin
        RS1_data_o = '0;
        RS1_pend_o = 1'b0;
        if (RS1_ADDR_i != ZERO) begin
            if (byp1) begin
                RS1_data_o = data_i;
            end else begin
                RS1_data_o = regs[RS1_ADDR_i];
                RS1_pend_o = pending[RS1_ADDR_i];
            end
        end
    end

    always_comb begin
        RS2_data_o = '0;
        RS2_pend_o = 1'b0;
        if (RS2_ADDR_i != ZERO) begin
            if (byp2) begin
                RS2_data_o = data_i;
            end else begin
                RS2_data_o = regs[RS2_ADDR_i];
                RS2_pend_o = pending[RS2_ADDR_i];
            end
        end
    end

endmodule

// File: tb/tb_regfile_scb.sv
// tb/tb_regfile_scb.sv - self-checking bench for regfile_scb, bypass on and off instances
module tb_regfile_scb;

    localparam int XLEN   = 32;
    localparam int NREGS  = 32;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [ADDR_W-1:0] rd_addr = '0;
    logic [XLEN-1:0]   wdata = '0;
    logic [ADDR_W-1:0] rs1_addr = '0;
    logic [ADDR_W-1:0] rs2_addr = '0;
    logic              rsv_en = 1'b0;
    logic [ADDR_W-1:0] rsv_addr = '0;
    logic              clr_req = 1'b0;

    logic [XLEN-1:0] b1_rs1, b1_rs2, b0_rs1, b0_rs2;
    logic            b1_p1, b1_p2, b0_p1, b0_p2;
    logic            b1_busy, b1_done, b0_busy, b0_done;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    regfile_scb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(1)) dut_b1 (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .RD_ADDR_i(rd_addr), .data_i(wdata),
        .RS1_ADDR_i(rs1_addr), .RS2_ADDR_i(rs2_addr), .RS1_data_o(b1_rs1), .RS2_data_o(b1_rs2),
        .RS1_pend_o(b1_p1), .RS2_pend_o(b1_p2), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
        .clr_req_i(clr_req), .clr_busy_o(b1_busy), .clr_done_o(b1_done)
    );

    regfile_scb #(.XLEN(XLEN), .NREGS(NREGS), .BYPASS(0)) dut_b0 (
        .clk(clk), .rst_n(rst_n), .wr_en_i(wr_en), .RD_ADDR_i(rd_addr), .data_i(wdata),
        .RS1_ADDR_i(rs1_addr), .RS2_ADDR_i(rs2_addr), .RS1_data_o(b0_rs1), .RS2_data_o(b0_rs2),
        .RS1_pend_o(b0_p1), .RS2_pend_o(b0_p2), .rsv_en_i(rsv_en), .rsv_addr_i(rsv_addr),
        .clr_req_i(clr_req), .clr_busy_o(b0_busy), .clr_done_o(b0_done)
    );

    // Reference model: architectural contents plus a queue of registers still to be cleared.
    logic [XLEN-1:0] m_regs [NREGS];
    bit              m_pend [NREGS];
    int              m_clr_q [$];
    bit              m_done;

    function automatic bit m_idle();
        return (m_clr_q.size() == 0) && !m_done;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                m_regs[i] = '0;
                m_pend[i] = 1'b0;
            end
            m_clr_q.delete();
            m_done = 1'b0;
        end else if (m_clr_q.size() != 0) begin
            m_regs[m_clr_q[0]] = '0;
            m_pend[m_clr_q[0]] = 1'b0;
            void'(m_clr_q.pop_front());
            if (m_clr_q.size() == 0) m_done = 1'b1;
        end else if (m_done) begin
            m_done = 1'b0;
        end else begin
            if (wr_en && rd_addr != 0) begin
                m_regs[rd_addr] = wdata;
                m_pend[rd_addr] = 1'b0;
            end
            if (rsv_en && rsv_addr != 0) m_pend[rsv_addr] = 1'b1;
            if (clr_req) begin
                for (int i = 1; i < NREGS; i++) m_clr_q.push_back(i);
            end
        end
    end

    function automatic logic [XLEN-1:0] exp_data(input logic [ADDR_W-1:0] a, input bit byp);
        if (a == 0) return '0;
        if (byp && m_idle() && wr_en && rd_addr == a) return wdata;
        return m_regs[a];
    endfunction

    function automatic bit exp_pend(input logic [ADDR_W-1:0] a, input bit byp);
        if (a == 0) return 1'b0;
        if (byp && m_idle() && wr_en && rd_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("b1_rs1_data", b1_rs1, exp_data(rs1_addr, 1'b1));
        check("b1_rs2_data", b1_rs2, exp_data(rs2_addr, 1'b1));
        check("b1_rs1_pend", 32'(b1_p1), 32'(exp_pend(rs1_addr, 1'b1)));
        check("b1_rs2_pend", 32'(b1_p2), 32'(exp_pend(rs2_addr, 1'b1)));
        check("b0_rs1_data", b0_rs1, exp_data(rs1_addr, 1'b0));
        check("b0_rs2_data", b0_rs2, exp_data(rs2_addr, 1'b0));
        check("b0_rs1_pend", 32'(b0_p1), 32'(exp_pend(rs1_addr, 1'b0)));
        check("b0_rs2_pend", 32'(b0_p2), 32'(exp_pend(rs2_addr, 1'b0)));
        check("b1_busy", 32'(b1_busy), 32'(m_clr_q.size() != 0));
        check("b0_busy", 32'(b0_busy), 32'(m_clr_q.size() != 0));
        check("b1_done", 32'(b1_done), 32'(m_done));
        check("b0_done", 32'(b0_done), 32'(m_done));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0; rsv_en = 1'b0; clr_req = 1'b0;
    endtask

    task automatic fill_all();
        for (int i = 1; i < NREGS; i++) begin
            wr_en = 1'b1; rd_addr = ADDR_W'(i); wdata = 32'h0101_0101 * i + 32'h10;
            step();
        end
        idle_inputs();
    endtask

    int busy_cnt, done_cnt;

    initial begin
        // Reset and sweep every address on both ports.
        rst_n = 1'b0;
        #1;
        for (int a = 0; a < NREGS; a++) begin
            rs1_addr = ADDR_W'(a); rs2_addr = ADDR_W'(NREGS - 1 - a);
            #1;
            check("rst_rs1", b1_rs1, 32'h0);
            check("rst_rs2_pend", 32'(b1_p2), 32'h0);
        end
        check("rst_busy", 32'(b1_busy), 32'h0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Plain write and x0 protection.
        wr_en = 1'b1; rd_addr = 5'd5; wdata = 32'hDEADBEEF;
        step();
        wr_en = 1'b1; rd_addr = 5'd0; wdata = 32'h1234;
        rs1_addr = 5'd5; rs2_addr = 5'd0;
        #1;
        check("lit_x5", b1_rs1, 32'hDEADBEEF);
        check("lit_x0_rs2", b1_rs2, 32'h0);
        step();
        idle_inputs();
        rs1_addr = 5'd0;
        #1;
        check("lit_x0_after_wr", b1_rs1, 32'h0);

        // Bypass versus pre-write value.
        wr_en = 1'b1; rd_addr = 5'd7; wdata = 32'hA5A5A5A5; rs1_addr = 5'd7;
        #1;
        check("lit_byp_on", b1_rs1, 32'hA5A5A5A5);
        check("lit_byp_off", b0_rs1, 32'h0);
        step();
        idle_inputs();
        #1;
        check("lit_byp_off_after", b0_rs1, 32'hA5A5A5A5);

        // Scoreboard.
        rsv_en = 1'b1; rsv_addr = 5'd9; rs2_addr = 5'd9;
        step();
        idle_inputs();
        #1;
        check("lit_rsv_x9", 32'(b1_p2), 32'h1);
        wr_en = 1'b1; rd_addr = 5'd9; wdata = 32'h55;
        step();
        idle_inputs();
        #1;
        check("lit_wb_x9", 32'(b0_p2), 32'h0);
        wr_en = 1'b1; rsv_en = 1'b1; rd_addr = 5'd9; rsv_addr = 5'd9; wdata = 32'h77;
        step();
        idle_inputs();
        #1;
        check("lit_wr_rsv_data", b0_rs2, 32'h77);
        check("lit_wr_rsv_pend", 32'(b0_p2), 32'h1);
        rsv_en = 1'b1; rsv_addr = 5'd0; rs1_addr = 5'd0;
        step();
        idle_inputs();
        #1;
        check("lit_rsv_x0", 32'(b1_p1), 32'h0);

        // Full clear sweep, with a write to x3 that must be ignored.
        fill_all();
        rsv_en = 1'b1; rsv_addr = 5'd12;
        step();
        idle_inputs();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        busy_cnt = 0; done_cnt = 0;
        rs1_addr = 5'd3; rs2_addr = 5'd12;
        for (int c = 0; c < 40; c++) begin
            wr_en = (c < 5); rd_addr = 5'd3; wdata = 32'hFFFF;
            #1;
            if (b1_busy) busy_cnt++;
            if (b1_done) done_cnt++;
            step();
        end
        idle_inputs();
        #1;
        check("lit_busy_cycles", 32'(busy_cnt), 32'd31);
        check("lit_done_pulses", 32'(done_cnt), 32'd1);
        check("lit_x3_cleared", b1_rs1, 32'h0);
        check("lit_x12_pend_cleared", 32'(b1_p2), 32'h0);

        // Reset in the middle of a sweep.
        fill_all();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int c = 0; c < 9; c++) step();
        #1;
        rs1_addr = 5'd31;
        rst_n = 1'b0;
        #1;
        check("lit_midrst_busy", 32'(b1_busy), 32'h0);
        check("lit_midrst_x31", b1_rs1, 32'h0);
        step();
        rst_n = 1'b1;
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (b1_done || b0_done) done_cnt++;
            step();
        end
        check("lit_midrst_no_done", 32'(done_cnt), 32'h0);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            wr_en    = ($urandom_range(0, 1) == 1);
            rd_addr  = ADDR_W'($urandom_range(0, NREGS - 1));
            wdata    = $urandom;
            rsv_en   = ($urandom_range(0, 9) < 3);
            rsv_addr = ($urandom_range(0, 3) == 0) ? rd_addr : ADDR_W'($urandom_range(0, NREGS - 1));
            rs1_addr = ($urandom_range(0, 2) == 0) ? rd_addr : ADDR_W'($urandom_range(0, NREGS - 1));
            rs2_addr = ($urandom_range(0, 3) == 0) ? rs1_addr : ADDR_W'($urandom_range(0, NREGS - 1));
            clr_req  = ($urandom_range(0, 199) == 0);
            step();
        end
        idle_inputs();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/regfile_scb.md
Name: regfile_scb

Overview:
Parametrised integer register file for the processor core: two combinational read ports and one synchronous write port, with hard-wired zero register. Adds optional write-to-read bypass, a per-register pending (scoreboard) bit set at issue and cleared at writeback, and a hardware clear sequencer that sweeps the array to zero. Sits between decode (read and reserve) and writeback (write) in the core datapath.

Parameters:
XLEN, 32, data width of each register.
NREGS, 32, number of registers; must be a power of two, at least 2.
ADDR_W, $clog2(NREGS), address width; derived, never overridden.
BYPASS, 1, 1 = same-cycle write forwards to read ports; 0 = reads return the pre-write value.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
rst_n  in  1  asynchronous, active-low reset.
wr_en_i  in  1  writeback write enable.
RD_ADDR_i  in  ADDR_W  write address.
data_i  in  XLEN  write data.
RS1_ADDR_i  in  ADDR_W  read port 1 address.
RS2_ADDR_i  in  ADDR_W  read port 2 address.
RS1_data_o  out  XLEN  read port 1 data, combinational.
RS2_data_o  out  XLEN  read port 2 data, combinational.
RS1_pend_o  out  1  pending bit of RS1_ADDR_i, combinational.
RS2_pend_o  out  1  pending bit of RS2_ADDR_i, combinational.
rsv_en_i  in  1  reserve request: marks rsv_addr_i pending.
rsv_addr_i  in  ADDR_W  register to reserve.
clr_req_i  in  1  start clear sweep.
clr_busy_o  out  1  high while sweep in progress.
clr_done_o  out  1  one-cycle pulse when sweep completes.

Behaviour:
- Reset (rst_n low, asynchronous): all registers 0, all pending bits 0, FSM IDLE, clr_busy_o 0, clr_done_o 0. Reset mid-sweep aborts immediately; no done pulse.
- Register 0: reads always 0, pending always 0; writes and reserves to address 0 ignored.
- Write: rising edge with wr_en_i=1, RD_ADDR_i!=0, FSM IDLE -> reg[RD_ADDR_i] <= data_i; pending[RD_ADDR_i] <= 0.
- Reserve: rising edge with rsv_en_i=1, rsv_addr_i!=0, FSM IDLE -> pending[rsv_addr_i] <= 1.
- Write and reserve to same address in same cycle: data written AND pending ends 1 (new producer wins).
- Reads: zero-latency. BYPASS=1 and wr_en_i=1 and RD_ADDR_i==RSx_ADDR_i!=0 and FSM IDLE -> RSx_data_o = data_i and RSx_pend_o = 0; otherwise array/pending contents. BYPASS=0 -> always array/pending contents.
- Both read ports may address the same register; both return identical values.
- Clear FSM states IDLE, SWEEP, DONE:
  IDLE: clr_req_i=1 -> SWEEP, idx <= 1.
  SWEEP: each cycle reg[idx] <= 0, pending[idx] <= 0; idx==NREGS-1 -> DONE else idx+1. clr_busy_o=1. Busy for exactly NREGS-1 cycles.
  DONE: clr_done_o=1 for one cycle, clr_busy_o=0, then IDLE.
- In SWEEP/DONE: wr_en_i, rsv_en_i, clr_req_i ignored (no effect, not queued); bypass disabled; reads return current array (swept entries 0, unswept entries old value).
- clr_busy_o, clr_done_o registered (FSM-state decodes).

Decomposition:
- Shared package: FSM state enum (IDLE, SWEEP, DONE), default XLEN/NREGS constants, zero-register address constant.
- Natural sub-module: regfile_clr_fsm (state, sweep index, busy/done); array, scoreboard and bypass muxes stay in top.

Test Plan:
- Reset, then read all addresses on both ports -> every RSx_data_o 0, RSx_pend_o 0, clr_busy_o 0.
- Write 0xDEADBEEF to x5, next cycle read RS1=x5, RS2=x0 -> 0xDEADBEEF and 0; write 0x1234 to x0 -> x0 still 0.
- BYPASS=1: same cycle wr x7=0xA5A5A5A5, RS1=x7 -> RS1_data_o 0xA5A5A5A5 immediately; rerun with BYPASS=0 -> old value until next edge.
- Reserve x9 -> RS2_pend_o 1 next cycle; write x9 -> pend 0; simultaneous write+reserve x9 -> data updated, pend 1; reserve x0 -> pend stays 0.
- Fill x1..x31 with nonzero, pulse clr_req_i -> clr_busy_o high 31 cycles, clr_done_o one pulse, all reads 0, pending 0; write to x3 during sweep ignored.
- Assert rst_n low at sweep cycle 10 -> outputs/state 0 asynchronously, no clr_done_o pulse after release.
